// File: rtl/ntt_axil_ctrl.sv
// ntt_axil_ctrl: AXI4-Lite control/status slave driving the NTT core.
// Define NTT_CTRL_PERF_CNT_EN to build the CYCLES counter at 0x0C.
module ntt_axil_ctrl #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 5,
  parameter int C_CNT_WIDTH        = 32
) (
  input  logic                            ACLK,
  input  logic                            ARESETn,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY,
  output logic                            ntt_start_o,
  output logic                            ntt_mode_o,
  input  logic                            ntt_done_i,
  output logic                            irq_o
);

  localparam int WW = C_S_AXI_ADDR_WIDTH - 2;
  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

  typedef enum logic [2:0] {
    SEL_CTRL,
    SEL_STATUS,
    SEL_IRQ_EN,
    SEL_CYCLES,
    SEL_NONE
  } sel_e;

  typedef enum logic {IDLE, RUN} state_e;

  function automatic sel_e decode(input logic [WW-1:0] word);
    sel_e sel;
    sel = SEL_NONE;
    unique case (1'b1)
      word == WW'(0): sel = SEL_CTRL;
      word == WW'(1): sel = SEL_STATUS;
      word == WW'(2): sel = SEL_IRQ_EN;
`ifdef NTT_CTRL_PERF_CNT_EN
      word == WW'(3): sel = SEL_CYCLES;
`endif
      default: ;
    endcase
    return sel;
  endfunction

  state_e state;
  logic   live;
  logic   busy;
  logic   done;
  logic   err;
  logic   irq_en;

  sel_e   aw_sel;
  sel_e   ar_sel;
  logic   wr_fire;
  logic   rd_fire;
  logic   ctrl_wr;
  logic   stat_wr;
  logic   en_wr;
  logic   start_req;
  logic   launch;
  logic   finish;
  logic   done_nx;
  logic   err_nx;
  logic   irq_en_nx;
  logic   rd_err;
  logic [C_S_AXI_DATA_WIDTH-1:0] rd_word;

  logic unused_bits;
  assign unused_bits = ^{S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0],
                         S_AXI_WDATA[C_S_AXI_DATA_WIDTH-1:3],
                         S_AXI_WSTRB[C_S_AXI_DATA_WIDTH/8-1:1]};

  // live keeps every ready low while reset is held and one cycle after
  assign wr_fire = live && S_AXI_AWVALID && S_AXI_WVALID && !S_AXI_BVALID;
  assign S_AXI_AWREADY = wr_fire;
  assign S_AXI_WREADY  = wr_fire;
  assign S_AXI_ARREADY = live && !S_AXI_RVALID;
  assign rd_fire = S_AXI_ARVALID && S_AXI_ARREADY;

  assign aw_sel = decode(S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:2]);
  assign ar_sel = decode(S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:2]);
  assign busy   = (state == RUN);

  always_comb begin
    ctrl_wr   = wr_fire && (aw_sel == SEL_CTRL);
    stat_wr   = wr_fire && (aw_sel == SEL_STATUS) && S_AXI_WSTRB[0];
    en_wr     = wr_fire && (aw_sel == SEL_IRQ_EN) && S_AXI_WSTRB[0];
    start_req = ctrl_wr && S_AXI_WSTRB[0] && S_AXI_WDATA[0];
    finish    = busy && ntt_done_i;
    launch    = !busy && start_req;

    // completion beats any clear issued in the same cycle
    done_nx = done;
    if (ctrl_wr || (stat_wr && S_AXI_WDATA[1]))
      done_nx = 1'b0;
    if (finish)
      done_nx = 1'b1;

    err_nx = err;
    if (stat_wr && S_AXI_WDATA[2])
      err_nx = 1'b0;
    if (busy && start_req)
      err_nx = 1'b1;

    irq_en_nx = en_wr ? S_AXI_WDATA[0] : irq_en;
  end

`ifdef NTT_CTRL_PERF_CNT_EN
  logic [C_CNT_WIDTH-1:0] cycles;

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      cycles <= '0;
    end else if (launch) begin
      cycles <= '0;
    end else if (busy && !ntt_done_i && !(&cycles)) begin
      cycles <= cycles + 1'b1;
    end
  end
`endif

  always_comb begin
    rd_word = '0;
    rd_err  = 1'b0;
    unique case (ar_sel)
      SEL_CTRL:   rd_word[1]   = ntt_mode_o;
      SEL_STATUS: rd_word[2:0] = {err, done, busy};
      SEL_IRQ_EN: rd_word[0]   = irq_en;
`ifdef NTT_CTRL_PERF_CNT_EN
      SEL_CYCLES: rd_word = C_S_AXI_DATA_WIDTH'(cycles);
`endif
      default:    rd_err = 1'b1;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state        <= IDLE;
      live         <= 1'b0;
      done         <= 1'b0;
      err          <= 1'b0;
      irq_en       <= 1'b1;
      ntt_start_o  <= 1'b0;
      ntt_mode_o   <= 1'b0;
      irq_o        <= 1'b0;
      S_AXI_BVALID <= 1'b0;
      S_AXI_BRESP  <= OKAY;
      S_AXI_RVALID <= 1'b0;
      S_AXI_RRESP  <= OKAY;
      S_AXI_RDATA  <= '0;
    end else begin
      live        <= 1'b1;
      done        <= done_nx;
      err         <= err_nx;
      irq_en      <= irq_en_nx;
      irq_o       <= done_nx & irq_en_nx;
      ntt_start_o <= launch;

      unique case (state)
        IDLE: if (launch) begin
          state      <= RUN;
          ntt_mode_o <= S_AXI_WDATA[1];
        end
        RUN: if (ntt_done_i)
          state <= IDLE;
      endcase

      if (wr_fire) begin
        S_AXI_BVALID <= 1'b1;
        S_AXI_BRESP  <= (aw_sel == SEL_NONE) ? SLVERR : OKAY;
      end else if (S_AXI_BREADY) begin
        S_AXI_BVALID <= 1'b0;
      end

      if (rd_fire) begin
        S_AXI_RVALID <= 1'b1;
        S_AXI_RDATA  <= rd_word;
        S_AXI_RRESP  <= rd_err ? SLVERR : OKAY;
      end else if (S_AXI_RREADY) begin
        S_AXI_RVALID <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ntt_axil_ctrl.sv
// tb_ntt_axil_ctrl: directed and random checks of ntt_axil_ctrl
// against a register-level model of the control window.
module tb_ntt_axil_ctrl;

`ifdef NTT_CTRL_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [4:0]  awaddr;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic [4:0]  araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;
  logic        start;
  logic        mode;
  logic        done_in;
  logic        irq;

  ntt_axil_ctrl dut (
    .ACLK          (clk),
    .ARESETn       (rst_n),
    .S_AXI_AWADDR  (awaddr),
    .S_AXI_AWVALID (awvalid),
    .S_AXI_AWREADY (awready),
    .S_AXI_WDATA   (wdata),
    .S_AXI_WSTRB   (wstrb),
    .S_AXI_WVALID  (wvalid),
    .S_AXI_WREADY  (wready),
    .S_AXI_BRESP   (bresp),
    .S_AXI_BVALID  (bvalid),
    .S_AXI_BREADY  (bready),
    .S_AXI_ARADDR  (araddr),
    .S_AXI_ARVALID (arvalid),
    .S_AXI_ARREADY (arready),
    .S_AXI_RDATA   (rdata),
    .S_AXI_RRESP   (rresp),
    .S_AXI_RVALID  (rvalid),
    .S_AXI_RREADY  (rready),
    .ntt_start_o   (start),
    .ntt_mode_o    (mode),
    .ntt_done_i    (done_in),
    .irq_o         (irq)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int start_cnt = 0;
  int start_at  = 0;
  int done_at   = 0;
  logic irq_n1;
  logic irq_after;

  // model of the register file
  logic        m_busy, m_done, m_err, m_irq_en, m_mode;
  int          m_starts;
  logic [31:0] m_cycles;

  always @(posedge clk) begin
    if (start) begin
      start_cnt++;
      start_at = cyc;
    end
    cyc++;
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit mapped(input logic [4:0] a);
    return (a[4:2] < 3'd3) || (a[4:2] == 3'd3 && PERF);
  endfunction

  function automatic logic [31:0] m_rd(input logic [4:0] a);
    case (a[4:2])
      3'd0:    return {30'd0, m_mode, 1'b0};
      3'd1:    return {29'd0, m_err, m_done, m_busy};
      3'd2:    return {31'd0, m_irq_en};
      3'd3:    return PERF ? m_cycles : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  task automatic model_reset();
    m_busy = 0; m_done = 0; m_err = 0;
    m_irq_en = 1; m_mode = 0; m_cycles = 0;
  endtask

  task automatic model_wr(input logic [4:0] a, input logic [31:0] d,
                          input logic [3:0] s, input bit wd);
    bit fin;
    fin = wd && m_busy;
    if (a[4:2] == 3'd0) begin
      m_done = 0;
      if (s[0] && d[0]) begin
        if (m_busy) m_err = 1;
        else begin
          m_busy = 1; m_mode = d[1];
          m_starts++; m_cycles = 0;
        end
      end
    end else if (a[4:2] == 3'd1 && s[0]) begin
      if (d[1]) m_done = 0;
      if (d[2]) m_err = 0;
    end else if (a[4:2] == 3'd2 && s[0]) begin
      m_irq_en = d[0];
    end
    if (fin) begin
      m_busy = 0; m_done = 1;
      m_cycles = 32'(done_at - start_at);
    end
  endtask

  task automatic axi_wr(input logic [4:0] a, input logic [31:0] d,
                        input logic [3:0] s, input bit wd,
                        output logic [1:0] resp);
    int n;
    @(negedge clk);
    awaddr = a; wdata = d; wstrb = s;
    awvalid = 1; wvalid = 1;
    #1;
    n = 0;
    while (!(awready && wready) && n < 20) begin
      @(negedge clk); #1; n++;
    end
    chk("aw_w_ready", 32'(awready && wready), 32'd1);
    if (wd) begin
      done_at = cyc; done_in = 1;
    end
    @(posedge clk); #1;
    awvalid = 0; wvalid = 0; done_in = 0;
    chk("bvalid_n1", 32'(bvalid), 32'd1);
    resp = bresp;
    irq_n1 = irq;
    @(posedge clk); #1;
    chk("bvalid_drop", 32'(bvalid), 32'd0);
  endtask

  task automatic axi_rd(input logic [4:0] a, output logic [31:0] d,
                        output logic [1:0] resp);
    int n;
    @(negedge clk);
    araddr = a; arvalid = 1;
    #1;
    n = 0;
    while (!arready && n < 20) begin
      @(negedge clk); #1; n++;
    end
    chk("arready", 32'(arready), 32'd1);
    @(posedge clk); #1;
    arvalid = 0;
    chk("rvalid_n1", 32'(rvalid), 32'd1);
    d = rdata; resp = rresp;
    @(posedge clk); #1;
    chk("rvalid_drop", 32'(rvalid), 32'd0);
  endtask

  task automatic do_wr(input logic [4:0] a, input logic [31:0] d,
                       input logic [3:0] s, input bit wd);
    logic [1:0] r;
    axi_wr(a, d, s, wd, r);
    model_wr(a, d, s, wd);
    chk("bresp", 32'(r), mapped(a) ? 32'd0 : 32'd2);
    chk("starts", 32'(start_cnt), 32'(m_starts));
    chk("irq", 32'(irq), 32'(m_done & m_irq_en));
  endtask

  task automatic do_rd(input logic [4:0] a, output logic [31:0] d);
    logic [1:0] r;
    axi_rd(a, d, r);
    chk("rdata", d, m_rd(a));
    chk("rresp", 32'(r), mapped(a) ? 32'd0 : 32'd2);
  endtask

  task automatic pulse_done();
    @(negedge clk);
    done_at = cyc; done_in = 1;
    @(posedge clk); #1;
    done_in = 0;
    irq_after = irq;
    if (m_busy) begin
      m_busy = 0; m_done = 1;
      m_cycles = 32'(done_at - start_at);
    end
    chk("irq_done", 32'(irq), 32'(m_done & m_irq_en));
  endtask

  logic [31:0] d;
  logic [4:0]  ra;
  logic [31:0] rd;
  logic [3:0]  rs;
  int          op;
  int          s0;

  initial begin
    rst_n = 0;
    awaddr = 0; awvalid = 0; wdata = 0; wstrb = 0; wvalid = 0;
    araddr = 0; arvalid = 0; bready = 1; rready = 1; done_in = 0;
    m_starts = 0;
    model_reset();

    repeat (3) @(negedge clk);
    chk("rst_awready", 32'(awready), 32'd0);
    chk("rst_arready", 32'(arready), 32'd0);
    chk("rst_bvalid", 32'(bvalid), 32'd0);
    chk("rst_rvalid", 32'(rvalid), 32'd0);
    chk("rst_resp", {28'd0, bresp, rresp}, 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_outs", {29'd0, start, mode, irq}, 32'd0);
    rst_n = 1;
    repeat (2) @(negedge clk);

    do_rd(5'h04, d);
    chk("status_rst", d, 32'h0);
    do_rd(5'h08, d);
    chk("irq_en_rst", d, 32'h1);

    // start an iNTT, done 1100 cycles after the strobe
    s0 = start_cnt;
    do_wr(5'h00, 32'h3, 4'hF, 0);
    chk("start_once", 32'(start_cnt - s0), 32'd1);
    chk("mode_intt", 32'(mode), 32'd1);
    do_wr(5'h00, 32'h0, 4'hF, 0);
    chk("mode_kept", 32'(mode), 32'd1);
    do_rd(5'h04, d);
    chk("status_run", d, 32'h1);
    while (cyc < start_at + 1099) @(negedge clk);
    pulse_done();
    chk("irq_m1", 32'(irq_after), 32'd1);
    do_rd(5'h04, d);
    chk("status_done", d, 32'h2);
    do_rd(5'h0C, d);
    chk("cycles", d, PERF ? 32'd1100 : 32'd0);
    do_wr(5'h00, 32'h0, 4'hF, 0);
    chk("irq_clr_n1", 32'(irq_n1), 32'd0);
    do_rd(5'h04, d);
    chk("status_clr", d, 32'h0);

    // start while busy raises ERR
    do_wr(5'h00, 32'h1, 4'hF, 0);
    s0 = start_cnt;
    do_wr(5'h00, 32'h1, 4'hF, 0);
    chk("no_restart", 32'(start_cnt - s0), 32'd0);
    do_rd(5'h04, d);
    chk("status_err", d, 32'h5);
    do_wr(5'h04, 32'h4, 4'hF, 0);
    do_rd(5'h04, d);
    chk("status_w1c", d, 32'h1);
    pulse_done();
    do_wr(5'h00, 32'h0, 4'hF, 0);

    // masked interrupt
    do_wr(5'h08, 32'h0, 4'hF, 0);
    do_wr(5'h00, 32'h1, 4'hF, 0);
    pulse_done();
    chk("irq_masked", 32'(irq_after), 32'd0);
    do_rd(5'h04, d);
    chk("status_masked", d, 32'h2);
    do_wr(5'h08, 32'h1, 4'hF, 0);
    chk("irq_unmask", 32'(irq_n1), 32'd1);
    do_wr(5'h00, 32'h0, 4'hF, 0);

    // unmapped window
    do_rd(5'h10, d);
    do_wr(5'h14, 32'hFFFF_FFFF, 4'hF, 0);
    do_wr(5'h0C, 32'h7, 4'hF, 0);
    do_rd(5'h04, d);
    do_rd(5'h08, d);
    chk("irq_en_kept", d, 32'h1);

    // W1C of DONE racing with completion: set wins
    do_wr(5'h00, 32'h1, 4'hF, 0);
    do_wr(5'h04, 32'h2, 4'hF, 1);
    do_rd(5'h04, d);
    chk("set_wins", d, 32'h2);
    // START racing with completion: no new start, ERR set
    do_wr(5'h00, 32'h1, 4'hF, 0);
    s0 = start_cnt;
    do_wr(5'h00, 32'h1, 4'hF, 1);
    chk("race_nostart", 32'(start_cnt - s0), 32'd0);
    do_rd(5'h04, d);
    chk("race_status", d, 32'h6);
    do_wr(5'h04, 32'h6, 4'hF, 0);

    // reset in the middle of a run
    do_wr(5'h00, 32'h3, 4'hF, 0);
    @(negedge clk);
    rst_n = 0;
    #1;
    chk("rst_mid_outs", {30'd0, mode, irq}, 32'd0);
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1;
    repeat (2) @(negedge clk);
    pulse_done();
    do_rd(5'h04, d);
    chk("rst_mid_status", d, 32'h0);
    do_rd(5'h00, d);

    // random traffic against the model
    for (int i = 0; i < 300; i++) begin
      op = $urandom_range(0, 9);
      ra = 5'($urandom_range(0, 31));
      rd = ($urandom_range(0, 3) == 0) ? 32'($urandom) : 32'($urandom_range(0, 7));
      rs = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
      if (op <= 3) begin
        do_wr(ra, rd, rs, 0);
      end else if (op == 4) begin
        do_wr(ra, rd, rs, 1);
      end else if (op <= 6) begin
        pulse_done();
      end else begin
        if (PERF && m_busy && ra[4:2] == 3'd3) ra = 5'h04;
        do_rd(ra, d);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
